scaling_regfile_axil: RTL and testbench
=======================================

# scaling_regfile_axil

AXI4-Lite slave register file for the scaling datapath, parametrised in register count and data width, with byte strobes, out-of-range error responses and optional shadow/commit double-buffering. It replaces the fixed four-register scaling control slave. It sits between the processor-side AXI interconnect and the scaler, and presents all control words as one flat bus. Shadow registers let software stage a full coefficient set and apply it atomically at a frame boundary.

## Interface
- DATA_WIDTH, 32: AXI data width and register width; 32 or 64.
- NUM_REGS, 8: number of registers, 1..256.
- ADDR_WIDTH, 10: AXI address width; must satisfy NUM_REGS*(DATA_WIDTH/8) <= 2**ADDR_WIDTH.
- ACLK  in  1  clock; all logic on rising edge.
- ARESETN  in  1  synchronous, active-low reset.
- S_AXI_AWADDR/AWPROT/AWVALID/AWREADY  in/in/in/out  ADDR_WIDTH/3/1/1  write address channel; AWPROT ignored.
- S_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  DATA_WIDTH/DATA_WIDTH/8/1/1  write data channel.
- S_AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  write response.
- S_AXI_ARADDR/ARPROT/ARVALID/ARREADY  in/in/in/out  ADDR_WIDTH/3/1/1  read address; ARPROT ignored.
- S_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  DATA_WIDTH/2/1/1  read data.
- commit  in  1  single-cycle pulse that copies shadow to active (shadow build only).
- regs_o  out  NUM_REGS*DATA_WIDTH  active register values; register i at bits [i*DATA_WIDTH +: DATA_WIDTH].

## Operation
- Decode: index = addr[ADDR_WIDTH-1 : log2(DATA_WIDTH/8)]; low byte-offset bits are ignored. If index >= NUM_REGS, the access gets SLVERR (2'b10); writes have no effect and reads return 0. Otherwise the response is OKAY (2'b00).
- Write FSM, states W_IDLE and W_RESP:
  - In W_IDLE, AWREADY=1 until AW has been captured, and WREADY=1 until W has been captured, independently. Either channel may arrive first or both may arrive together.
  - Once both are captured: the storage is updated byte-wise by WSTRB, BRESP is set, and the FSM moves to W_RESP with BVALID=1.
  - In W_RESP, AWREADY=WREADY=0. BVALID is held until the BVALID&BREADY edge, then the FSM returns to W_IDLE.
- Read FSM, states R_IDLE and R_DATA:
  - In R_IDLE, ARREADY=1. On the AR handshake, RDATA and RRESP are registered and the FSM moves to R_DATA with RVALID=1.
  - RDATA/RRESP stay stable until RREADY, then the FSM returns to R_IDLE.
- Only one transaction is outstanding per channel. The read and write channels run fully concurrently.
- Read-back returns the storage written by AXI: the shadow copy in shadow builds, the active copy otherwise.
- Reset: all registers (shadow and active) = 0; AWREADY=WREADY=ARREADY=0 during reset; BVALID=RVALID=0; BRESP=RRESP=0; RDATA=0; capture flags cleared; both FSMs go to idle.

## Timing
- Write latency: BVALID rises on the edge after the later of the AW/W handshakes, and regs_o (non-shadow build) changes on that same edge. Back-to-back writes with BREADY tied high complete one every 2 cycles.
- Read latency: RVALID rises on the edge after the AR handshake (1 cycle). Back-to-back reads with RREADY tied high complete one every 2 cycles.
- ARREADY is 1 in the first cycle after reset deassertion. AWREADY and WREADY are also 1 in that cycle.
- A read and a write to the same index handshaking in the same cycle: the read returns the pre-write value.
- Mid-transaction reset: the transaction is dropped with no response; any partially captured AW or W is discarded.
- WSTRB=0 with a valid index: no bytes change, and the write still gets an OKAY response.

## Configuration
- SCALING_REGFILE_SHADOW_EN defined:
  - AXI writes go to the shadow bank. regs_o drives the active bank.
  - A commit high at an edge copies every shadow register into the active bank at that edge.
  - An AXI write landing on the same edge goes into shadow only and appears at the next commit.
- SCALING_REGFILE_SHADOW_EN undefined: single bank only; commit is ignored and regs_o reflects writes directly.

## Test plan
- Reset, then write 0x1,0x2,…,0x8 to addresses 0x00..0x1C and read each back -> every read returns the written value with RRESP=0, and BRESP=0 for every write.
- Write 0xDEADBEEF to 0x20 with NUM_REGS=8, then read 0x20 -> BRESP=2'b10; read returns RDATA=0 with RRESP=2'b10; regs_o unchanged.
- Write 0xFFFFFFFF to reg 3, then write 0x12345678 with WSTRB=4'b0101 -> reg 3 reads 0xFF34FF78.
- Present W three cycles before AW, and separately AW before W; hold BREADY low for 4 cycles -> exactly one register update; BVALID stays high until BREADY; AWREADY and WREADY are 0 while in W_RESP.
- Shadow build: write 0xA to reg 0 -> reg-0 field of regs_o stays 0 and readback = 0xA. Pulse commit -> regs_o reg-0 field = 0xA the next cycle. Write 0xB in the same cycle as a commit -> regs_o keeps 0xA until the next commit.
- Assert ARESETN=0 while BVALID=1 and RVALID=1 -> both are 0 after the edge, all registers read 0 afterwards, and AWREADY/WREADY/ARREADY are 1 in the first cycle after reset release.

Source files
------------

// File: rtl/scaling_regfile_axil.sv
// AXI4-Lite register file for the scaling datapath: byte strobes, SLVERR on out-of-range index.
// Define SCALING_REGFILE_SHADOW_EN for a shadow bank that is copied to regs_o on a commit pulse.
module scaling_regfile_axil #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                           ACLK,
  input  logic                           ARESETN,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                     S_AXI_AWPROT,
  input  logic                           S_AXI_AWVALID,
  output logic                           S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                           S_AXI_WVALID,
  output logic                           S_AXI_WREADY,
  output logic [1:0]                     S_AXI_BRESP,
  output logic                           S_AXI_BVALID,
  input  logic                           S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                     S_AXI_ARPROT,
  input  logic                           S_AXI_ARVALID,
  output logic                           S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                     S_AXI_RRESP,
  output logic                           S_AXI_RVALID,
  input  logic                           S_AXI_RREADY,
  input  logic                           commit,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);
  localparam int          STRB_W = DATA_WIDTH / 8;
  localparam int          OFF_W  = $clog2(STRB_W);
  localparam int          IDX_W  = ADDR_WIDTH - OFF_W;
  localparam logic [31:0] NREGS  = NUM_REGS;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic { W_IDLE, W_RESP } w_state_t;
  typedef enum logic { R_IDLE, R_DATA } r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  // AXI-visible bank: shadow in shadow builds, the only bank otherwise
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] wbank;

  logic              aw_done, w_done;
  logic [IDX_W-1:0]  aw_idx_q, wr_idx, rd_idx;
  logic [DATA_WIDTH-1:0] wdata_q, wr_data, rd_word;
  logic [STRB_W-1:0] wstrb_q, wr_strb;
  logic              aw_hs, w_hs, ar_hs, wr_fire, wr_ok, rd_ok;

  // Readies are gated by reset so they read 0 while ARESETN is low
  assign S_AXI_AWREADY = ARESETN && (w_state == W_IDLE) && !aw_done;
  assign S_AXI_WREADY  = ARESETN && (w_state == W_IDLE) && !w_done;
  assign S_AXI_ARREADY = ARESETN && (r_state == R_IDLE);
  assign S_AXI_BVALID  = (w_state == W_RESP);
  assign S_AXI_RVALID  = (r_state == R_DATA);

  assign aw_hs   = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs    = S_AXI_WVALID  && S_AXI_WREADY;
  assign ar_hs   = S_AXI_ARVALID && S_AXI_ARREADY;
  assign wr_fire = (w_state == W_IDLE) && (aw_done || aw_hs) && (w_done || w_hs);
  assign wr_idx  = aw_done ? aw_idx_q : S_AXI_AWADDR[ADDR_WIDTH-1:OFF_W];
  assign wr_data = w_done  ? wdata_q  : S_AXI_WDATA;
  assign wr_strb = w_done  ? wstrb_q  : S_AXI_WSTRB;
  assign wr_ok   = 32'(wr_idx) < NREGS;
  assign rd_idx  = S_AXI_ARADDR[ADDR_WIDTH-1:OFF_W];
  assign rd_ok   = 32'(rd_idx) < NREGS;

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE: if (wr_fire) w_next = W_RESP;
      W_RESP: if (S_AXI_BREADY) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE: if (ar_hs) r_next = R_DATA;
      R_DATA: if (S_AXI_RREADY) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (rd_idx == IDX_W'(i)) rd_word = wbank[i];
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      w_state     <= W_IDLE;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      aw_idx_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      S_AXI_BRESP <= RESP_OKAY;
    end else begin
      w_state <= w_next;
      if (wr_fire) begin
        aw_done     <= 1'b0;
        w_done      <= 1'b0;
        S_AXI_BRESP <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else begin
        if (aw_hs) begin
          aw_done  <= 1'b1;
          aw_idx_q <= S_AXI_AWADDR[ADDR_WIDTH-1:OFF_W];
        end
        if (w_hs) begin
          w_done  <= 1'b1;
          wdata_q <= S_AXI_WDATA;
          wstrb_q <= S_AXI_WSTRB;
        end
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      wbank <= '0;
    end else if (wr_fire && wr_ok) begin
      for (int i = 0; i < NUM_REGS; i++)
        if (wr_idx == IDX_W'(i))
          for (int b = 0; b < STRB_W; b++)
            if (wr_strb[b]) wbank[i][b*8 +: 8] <= wr_data[b*8 +: 8];
    end
  end

  // Read data is taken before the same-edge write lands, so it sees the old value
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_state     <= R_IDLE;
      S_AXI_RDATA <= '0;
      S_AXI_RRESP <= RESP_OKAY;
    end else begin
      r_state <= r_next;
      if (ar_hs) begin
        S_AXI_RDATA <= rd_ok ? rd_word : '0;
        S_AXI_RRESP <= rd_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  logic unused_sigs;
`ifdef SCALING_REGFILE_SHADOW_EN
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] act_bank;

  always_ff @(posedge ACLK) begin
    if (!ARESETN) act_bank <= '0;
    else if (commit) act_bank <= wbank;
  end

  assign regs_o      = act_bank;
  assign unused_sigs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[OFF_W-1:0], S_AXI_ARADDR[OFF_W-1:0]};
`else
  assign regs_o      = wbank;
  assign unused_sigs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[OFF_W-1:0], S_AXI_ARADDR[OFF_W-1:0], commit};
`endif
endmodule

// File: tb/tb_scaling_regfile_axil.sv
// Scoreboard bench for scaling_regfile_axil: expectations queued at issue, popped by B/R monitors.
module tb_scaling_regfile_axil;
  localparam int DW = 32, NR = 8, AW = 10;

  logic ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  logic ARESETN;
  logic [AW-1:0] S_AXI_AWADDR, S_AXI_ARADDR;
  logic [2:0] S_AXI_AWPROT, S_AXI_ARPROT;
  logic S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
  logic [DW-1:0] S_AXI_WDATA, S_AXI_RDATA;
  logic [DW/8-1:0] S_AXI_WSTRB;
  logic [1:0] S_AXI_BRESP, S_AXI_RRESP;
  logic S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
  logic S_AXI_RVALID, S_AXI_RREADY, commit;
  logic [NR*DW-1:0] regs_o;

  scaling_regfile_axil #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT), .S_AXI_AWVALID(S_AXI_AWVALID),
    .S_AXI_AWREADY(S_AXI_AWREADY), .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP),
    .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR),
    .S_AXI_ARPROT(S_AXI_ARPROT), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID),
    .S_AXI_RREADY(S_AXI_RREADY), .commit(commit), .regs_o(regs_o)
  );

  int chk = 0, err = 0, bcnt = 0, rcnt = 0;
  logic [1:0]  bq[$];
  logic [33:0] rq[$];
  logic [31:0] shw[NR];    // what AXI writes and reads back
  logic [31:0] act_m[NR];  // what regs_o should show in shadow builds

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
    chk++;
    if (got !== want) begin
      err++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  always @(negedge ACLK) begin
    if (ARESETN && S_AXI_BVALID && S_AXI_BREADY) begin
      if (bq.size() == 0) check("b_unexpected", 1, 0);
      else check("bresp", 256'(S_AXI_BRESP), 256'(bq.pop_front()));
      bcnt++;
    end
  end

  always @(negedge ACLK) begin
    if (ARESETN && S_AXI_RVALID && S_AXI_RREADY) begin
      if (rq.size() == 0) check("r_unexpected", 1, 0);
      else check("rresp_rdata", 256'({S_AXI_RRESP, S_AXI_RDATA}), 256'(rq.pop_front()));
      rcnt++;
    end
  end

  function automatic logic [255:0] exp_regs();
    logic [255:0] v = '0;
    for (int i = 0; i < NR; i++)
`ifdef SCALING_REGFILE_SHADOW_EN
      v[i*32 +: 32] = act_m[i];
`else
      v[i*32 +: 32] = shw[i];
`endif
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NR; i++) begin shw[i] = 0; act_m[i] = 0; end
  endtask

  task automatic model_commit();
    for (int i = 0; i < NR; i++) act_m[i] = shw[i];
  endtask

  task automatic wr_expect(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx = int'(a >> 2);
    if (idx < NR) begin
      for (int b = 0; b < 4; b++) if (s[b]) shw[idx][b*8 +: 8] = d[b*8 +: 8];
      bq.push_back(2'b00);
    end else bq.push_back(2'b10);
  endtask

  task automatic rd_expect(input logic [9:0] a);
    int idx = int'(a >> 2);
    if (idx < NR) rq.push_back({2'b00, shw[idx]});
    else rq.push_back({2'b10, 32'h0});
  endtask

  task automatic wr_drive(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int awd, input int wd);
    int cyc = 0;
    bit aw_ok = 0, w_ok = 0, aw_t, w_t;
    while (!(aw_ok && w_ok) && cyc < 40) begin
      @(negedge ACLK);
      S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
      S_AXI_AWVALID = !aw_ok && cyc >= awd;
      S_AXI_WVALID  = !w_ok && cyc >= wd;
      #1;
      aw_t = S_AXI_AWVALID && S_AXI_AWREADY;
      w_t  = S_AXI_WVALID && S_AXI_WREADY;
      @(posedge ACLK);
      aw_ok |= aw_t; w_ok |= w_t;
      cyc++;
    end
    #1 S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    if (!(aw_ok && w_ok)) check("wr_handshake_timeout", 0, 1);
  endtask

  task automatic rd_drive(input logic [9:0] a);
    int cyc = 0;
    bit ok = 0, t;
    while (!ok && cyc < 40) begin
      @(negedge ACLK);
      S_AXI_ARADDR = a; S_AXI_ARVALID = 1;
      #1 t = S_AXI_ARREADY;
      @(posedge ACLK);
      ok = t; cyc++;
    end
    #1 S_AXI_ARVALID = 0;
    if (!ok) check("rd_handshake_timeout", 0, 1);
  endtask

  task automatic wait_b(input int n);
    int t = 0;
    while (bcnt < n && t < 60) begin @(negedge ACLK); t++; end
    if (bcnt < n) check("b_timeout", 0, 1);
  endtask

  task automatic wait_r(input int n);
    int t = 0;
    while (rcnt < n && t < 60) begin @(negedge ACLK); t++; end
    if (rcnt < n) check("r_timeout", 0, 1);
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s,
                    input int awd = 0, input int wd = 0);
    int bt = bcnt;
    wr_expect(a, d, s);
    wr_drive(a, d, s, awd, wd);
    wait_b(bt + 1);
  endtask

  task automatic rd(input logic [9:0] a);
    int rt = rcnt;
    rd_expect(a);
    rd_drive(a);
    wait_r(rt + 1);
  endtask

  task automatic commit_drive();
    @(negedge ACLK) commit = 1;
    @(posedge ACLK);
    #1 commit = 0;
  endtask

  task automatic commit_pulse();
    model_commit();
    commit_drive();
  endtask

  // Response held with BREADY low: BVALID must stay up and both write readies stay low
  task automatic hold_test(input logic [9:0] a, input logic [31:0] d, input int awd, input int wd);
    int bt = bcnt;
    S_AXI_BREADY = 0;
    wr_expect(a, d, 4'hF);
    wr_drive(a, d, 4'hF, awd, wd);
    repeat (4) begin
      @(negedge ACLK);
      check("bvalid_held", 256'(S_AXI_BVALID), 1);
      check("wready_in_resp", 256'({S_AXI_AWREADY, S_AXI_WREADY}), 0);
    end
    S_AXI_BREADY = 1;
    wait_b(bt + 1);
    check("regs_after_hold", regs_o, exp_regs());
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    ARESETN = 0; commit = 0;
    S_AXI_AWADDR = 0; S_AXI_AWPROT = 0; S_AXI_AWVALID = 0;
    S_AXI_WDATA = 0; S_AXI_WSTRB = 0; S_AXI_WVALID = 0; S_AXI_BREADY = 1;
    S_AXI_ARADDR = 0; S_AXI_ARPROT = 0; S_AXI_ARVALID = 0; S_AXI_RREADY = 1;
    model_clear();
    repeat (3) @(negedge ACLK);
    check("reset_valids", 256'({S_AXI_BVALID, S_AXI_RVALID}), 0);
    check("reset_readies", 256'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 0);
    check("reset_rdata_resp", 256'({S_AXI_RDATA, S_AXI_RRESP, S_AXI_BRESP}), 0);
    check("reset_regs", regs_o, 0);
    ARESETN = 1;
    #1 check("ready_after_reset", 256'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 256'h7);

    for (int i = 0; i < NR; i++) wr(10'(i * 4), 32'(i + 1), 4'hF);
    for (int i = 0; i < NR; i++) rd(10'(i * 4));
    check("regs_fill", regs_o, exp_regs());

    wr(10'h20, 32'hDEADBEEF, 4'hF);
    rd(10'h20);
    rd(10'h3FC);
    check("regs_after_oob", regs_o, exp_regs());

    wr(10'h0C, 32'hFFFFFFFF, 4'hF);
    wr(10'h0C, 32'h12345678, 4'b0101);
    rd(10'h0C);
    wr(10'h0C, 32'h0BADF00D, 4'h0);
    rd(10'h0C);

    hold_test(10'h14, 32'hCAFE0001, 3, 0);
    hold_test(10'h18, 32'hCAFE0002, 0, 3);
    rd(10'h14); rd(10'h18);

    // Shadow staging and commit; a write on the commit edge waits for the next commit
    wr(10'h00, 32'hA, 4'hF);
    check("regs_before_commit", regs_o, exp_regs());
    rd(10'h00);
    commit_pulse();
    check("regs_after_commit", regs_o, exp_regs());
    begin
      int bt = bcnt;
      model_commit();
      wr_expect(10'h00, 32'hB, 4'hF);
      fork
        wr_drive(10'h00, 32'hB, 4'hF, 0, 0);
        commit_drive();
      join
      wait_b(bt + 1);
    end
    check("regs_commit_same_edge", regs_o, exp_regs());
    commit_pulse();
    check("regs_second_commit", regs_o, exp_regs());

    begin
      int bt = bcnt, rt = rcnt;
      rd_expect(10'h08);
      wr_expect(10'h08, 32'h55AA55AA, 4'hF);
      fork
        wr_drive(10'h08, 32'h55AA55AA, 4'hF, 0, 0);
        rd_drive(10'h08);
      join
      wait_b(bt + 1); wait_r(rt + 1);
      rd(10'h08);
    end

    for (int n = 0; n < 80; n++) begin
      logic [9:0] a = 10'($urandom_range(0, 47));
      if ($urandom_range(0, 1) == 1)
        wr(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3));
      else rd(a);
      if ($urandom_range(0, 7) == 0) begin
        commit_pulse();
        check("regs_random", regs_o, exp_regs());
      end
    end
    check("regs_random_end", regs_o, exp_regs());

    // Reset with both responses pending: they are dropped and everything clears
    S_AXI_BREADY = 0; S_AXI_RREADY = 0;
    fork
      wr_drive(10'h04, 32'h77777777, 4'hF, 0, 0);
      rd_drive(10'h04);
    join
    @(negedge ACLK);
    check("both_pending", 256'({S_AXI_BVALID, S_AXI_RVALID}), 256'h3);
    ARESETN = 0;
    @(posedge ACLK);
    #1;
    check("valids_dropped", 256'({S_AXI_BVALID, S_AXI_RVALID}), 0);
    check("readies_in_reset", 256'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 0);
    bq.delete(); rq.delete();
    model_clear();
    @(negedge ACLK);
    ARESETN = 1; S_AXI_BREADY = 1; S_AXI_RREADY = 1;
    #1 check("ready_after_rereset", 256'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 256'h7);
    check("regs_after_rereset", regs_o, 0);
    for (int i = 0; i < NR; i++) rd(10'(i * 4));
    wr(10'h1C, 32'h13572468, 4'hF);
    rd(10'h1C);

    repeat (3) @(negedge ACLK);
    check("queues_drained", 256'(bq.size() + rq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end
endmodule
